// File: rtl/player_action_seq_pkg.sv
// Shared state codes, widths and default action lengths for player_action_seq.
// Durations must stay consistent with the renderer's startup/pullback frames.
package player_action_seq_pkg;

    localparam int STATE_DEPTH        = 3;
    localparam int SPRITE_INDEX_DEPTH = 5;

    localparam int WALK_CYCLE_DEF     = 24;
    localparam int GRAB_DURATION_DEF  = 20;
    localparam int KICK_DURATION_DEF  = 16;

    typedef enum logic [STATE_DEPTH-1:0] {
        NOTHING       = 3'd0,
        WALK_FORWARD  = 3'd1,
        WALK_BACKWARD = 3'd2,
        GRAB          = 3'd3,
        KICK          = 3'd4,
        BLOCK         = 3'd5,
        WIN           = 3'd6,
        LOSE          = 3'd7
    } act_state_t;

    // Last timer value for an animation of 'frames' frames,
    // clamped so it always fits a 'width'-bit timer.
    function automatic int last_frame(input int frames, input int width);
        int span;
        span = 1 << width;
        if (frames < 1) return 0;
        if (frames > span) return span - 1;
        return frames - 1;
    endfunction

    // Button priority: lose > win > kick > grab > block > walk.
    // Both walk directions at once cancel out to NOTHING.
    function automatic act_state_t pick_request(
        input logic lose,
        input logic win,
        input logic kick,
        input logic grab,
        input logic block,
        input logic fwd,
        input logic bwd
    );
        if (lose) return LOSE;
        if (win) return WIN;
        if (kick) return KICK;
        if (grab) return GRAB;
        if (block) return BLOCK;
        if (fwd && bwd) return NOTHING;
        if (fwd) return WALK_FORWARD;
        if (bwd) return WALK_BACKWARD;
        return NOTHING;
    endfunction

endpackage

// File: rtl/player_action_seq_action_timer_cnt.sv
// Frame-tick counter with sync clear and wrap/saturate at a terminal value.
// Used as the per-state animation timer of player_action_seq.
module action_timer_cnt #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         tick,
    input  logic         clr,
    input  logic         wrap,
    input  logic [W-1:0] last,
    output logic [W-1:0] count
);

    // Advance once per tick; hold or wrap on reaching the terminal value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (tick) begin
            if (clr) begin
                count <= '0;
            end else if (count >= last) begin
                count <= wrap ? '0 : count;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/player_action_seq.sv
// Per-player animation state sequencer driving sprite state/timer inputs.
// Optional INPUT_BUFFER_EN keeps one kick/grab press made while busy.
module player_action_seq
    import player_action_seq_pkg::*;
#(
    parameter int WALK_CYCLE    = WALK_CYCLE_DEF,
    parameter int GRAB_DURATION = GRAB_DURATION_DEF,
    parameter int KICK_DURATION = KICK_DURATION_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          frame_tick,
    input  logic                          btn_forward,
    input  logic                          btn_backward,
    input  logic                          btn_grab,
    input  logic                          btn_kick,
    input  logic                          btn_block,
    input  logic                          game_win,
    input  logic                          game_lose,
    output logic [STATE_DEPTH-1:0]        state,
    output logic [SPRITE_INDEX_DEPTH-1:0] action_timer,
    output logic                          busy,
    output logic                          action_done
);

    localparam int TW = SPRITE_INDEX_DEPTH;

    localparam logic [TW-1:0] T_MAX     = '1;
    localparam logic [TW-1:0] WALK_LAST =
        TW'(last_frame(WALK_CYCLE, TW));
    localparam logic [TW-1:0] GRAB_LAST =
        TW'(last_frame(GRAB_DURATION, TW));
    localparam logic [TW-1:0] KICK_LAST =
        TW'(last_frame(KICK_DURATION, TW));

    act_state_t    state_q;
    act_state_t    state_nx;
    act_state_t    req;
    logic [TW-1:0] timer;
    logic [TW-1:0] last;
    logic          clr;
    logic          wrap;
    logic          done_nx;
    logic          done_q;
    logic          buf_valid;
    logic          buf_kick;

    assign req = pick_request(
        game_lose, game_win, btn_kick, btn_grab,
        btn_block, btn_forward, btn_backward
    );

    assign busy         = (state_q == GRAB) || (state_q == KICK);
    assign state        = state_q;
    assign action_timer = timer;
    assign action_done  = done_q;

    // Next state and timer mode; only takes effect on a frame tick.
    always_comb begin
        state_nx = state_q;
        clr      = 1'b0;
        wrap     = 1'b0;
        last     = T_MAX;
        done_nx  = 1'b0;
        unique case (state_q)
            WIN, LOSE: begin
            end
            GRAB, KICK: begin
                last = (state_q == GRAB) ? GRAB_LAST : KICK_LAST;
                if (game_lose || game_win) begin
                    // Round end aborts the move without a done pulse.
                    state_nx = req;
                    clr      = 1'b1;
                end else if (timer >= last) begin
                    done_nx = 1'b1;
                    clr     = 1'b1;
                    if (!buf_valid) begin
                        state_nx = req;
                    end else if (buf_kick) begin
                        state_nx = KICK;
                    end else begin
                        state_nx = GRAB;
                    end
                end
            end
            WALK_FORWARD, WALK_BACKWARD: begin
                wrap = 1'b1;
                last = WALK_LAST;
                if (req != state_q) begin
                    state_nx = req;
                    clr      = 1'b1;
                end
            end
            default: begin
                if (req != state_q) begin
                    state_nx = req;
                    clr      = 1'b1;
                end
            end
        endcase
    end

    // State register and one-clock completion pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= NOTHING;
            done_q  <= 1'b0;
        end else begin
            done_q <= frame_tick & done_nx;
            if (frame_tick) begin
                state_q <= state_nx;
            end
        end
    end

    action_timer_cnt #(
        .W(TW)
    ) u_timer (
        .clk  (clk),
        .reset(reset),
        .tick (frame_tick),
        .clr  (clr),
        .wrap (wrap),
        .last (last),
        .count(timer)
    );

`ifdef INPUT_BUFFER_EN
    logic kick_d;
    logic grab_d;
    logic kick_rise;
    logic grab_rise;
    logic consume;
    logic term_nx;

    assign kick_rise = btn_kick & ~kick_d;
    assign grab_rise = btn_grab & ~grab_d;
    assign consume   = frame_tick & done_nx;
    assign term_nx   = frame_tick &
        ((state_nx == WIN) || (state_nx == LOSE));

    // One-entry press buffer; newest press while busy wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            kick_d    <= 1'b0;
            grab_d    <= 1'b0;
            buf_valid <= 1'b0;
            buf_kick  <= 1'b0;
        end else begin
            kick_d <= btn_kick;
            grab_d <= btn_grab;
            if (consume || term_nx) begin
                buf_valid <= 1'b0;
            end else if (busy && (kick_rise || grab_rise)) begin
                buf_valid <= 1'b1;
                buf_kick  <= kick_rise;
            end
        end
    end
`else
    assign buf_valid = 1'b0;
    assign buf_kick  = 1'b0;
`endif

endmodule

// File: tb/tb_player_action_seq.sv
// Directed bench for player_action_seq with hand-computed expectations.
// Buffer expectations follow INPUT_BUFFER_EN when it is defined.
module tb_player_action_seq;
    import player_action_seq_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       frame_tick = 1'b0;
    logic       btn_forward = 1'b0;
    logic       btn_backward = 1'b0;
    logic       btn_grab = 1'b0;
    logic       btn_kick = 1'b0;
    logic       btn_block = 1'b0;
    logic       game_win = 1'b0;
    logic       game_lose = 1'b0;
    logic [2:0] state;
    logic [4:0] action_timer;
    logic       busy;
    logic       action_done;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    player_action_seq dut (
        .clk         (clk),
        .reset       (reset),
        .frame_tick  (frame_tick),
        .btn_forward (btn_forward),
        .btn_backward(btn_backward),
        .btn_grab    (btn_grab),
        .btn_kick    (btn_kick),
        .btn_block   (btn_block),
        .game_win    (game_win),
        .game_lose   (game_lose),
        .state       (state),
        .action_timer(action_timer),
        .busy        (busy),
        .action_done (action_done)
    );

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic expect_all(
        input string tag, input int st, input int tm,
        input int bz, input int dn
    );
        check({tag, "_state"}, int'(state), st);
        check({tag, "_timer"}, int'(action_timer), tm);
        check({tag, "_busy"}, int'(busy), bz);
        check({tag, "_done"}, int'(action_done), dn);
    endtask

    task automatic tick();
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
    endtask

    task automatic clear_btns();
        btn_forward  = 1'b0;
        btn_backward = 1'b0;
        btn_grab     = 1'b0;
        btn_kick     = 1'b0;
        btn_block    = 1'b0;
        game_win     = 1'b0;
        game_lose    = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        clear_btns();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        clear_btns();
        repeat (3) @(negedge clk);
        expect_all("rst", int'(NOTHING), 0, 0, 0);
        reset = 1'b1;
        @(negedge clk);

        for (int k = 1; k <= 40; k++) begin
            tick();
            check("idle_timer", int'(action_timer), (k < 31) ? k : 31);
        end
        check("idle_state", int'(state), int'(NOTHING));

        btn_forward = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            check("walk_state", int'(state), int'(WALK_FORWARD));
            check("walk_timer", int'(action_timer), (k - 1) % 24);
        end
        btn_forward = 1'b0;
        tick();
        expect_all("walk_rel", int'(NOTHING), 0, 0, 0);

        btn_kick = 1'b1;
        tick();
        btn_kick = 1'b0;
        expect_all("kick_go", int'(KICK), 0, 1, 0);
        for (int k = 1; k <= 15; k++) begin
            if (k == 4) btn_block = 1'b1;
            tick();
            btn_block = 1'b0;
            expect_all("kick_run", int'(KICK), k, 1, 0);
        end
        tick();
        expect_all("kick_done", int'(NOTHING), 0, 0, 1);
        @(negedge clk);
        check("done_1clk", int'(action_done), 0);

        btn_kick = 1'b1;
        btn_grab = 1'b1;
        tick();
        btn_kick = 1'b0;
        btn_grab = 1'b0;
        expect_all("kg_pri", int'(KICK), 0, 1, 0);
        repeat (16) tick();
        expect_all("kg_end", int'(NOTHING), 0, 0, 1);

        btn_forward = 1'b1;
        tick();
        tick();
        expect_all("fwd", int'(WALK_FORWARD), 1, 0, 0);
        btn_forward  = 1'b0;
        btn_backward = 1'b1;
        tick();
        expect_all("rev", int'(WALK_BACKWARD), 0, 0, 0);
        btn_forward = 1'b1;
        tick();
        expect_all("both_dir", int'(NOTHING), 0, 0, 0);
        clear_btns();
        tick();
        expect_all("idle_again", int'(NOTHING), 1, 0, 0);

        btn_block = 1'b1;
        tick();
        expect_all("blk_go", int'(BLOCK), 0, 0, 0);
        repeat (40) tick();
        expect_all("blk_sat", int'(BLOCK), 31, 0, 0);
        btn_block = 1'b0;
        tick();
        expect_all("blk_rel", int'(NOTHING), 0, 0, 0);

        btn_grab = 1'b1;
        tick();
        btn_grab = 1'b0;
        expect_all("grab_go", int'(GRAB), 0, 1, 0);
        repeat (7) tick();
        expect_all("grab_7", int'(GRAB), 7, 1, 0);
        game_lose = 1'b1;
        tick();
        expect_all("abort", int'(LOSE), 0, 0, 0);
        game_lose = 1'b0;
        tick();
        expect_all("lose_hold", int'(LOSE), 1, 0, 0);
        btn_kick = 1'b1;
        game_win = 1'b1;
        tick();
        expect_all("lose_term", int'(LOSE), 2, 0, 0);

        do_reset();
        game_win  = 1'b1;
        game_lose = 1'b1;
        tick();
        expect_all("win_lose", int'(LOSE), 0, 0, 0);

        do_reset();
        game_win = 1'b1;
        tick();
        game_win = 1'b0;
        expect_all("win_go", int'(WIN), 0, 0, 0);
        repeat (35) tick();
        expect_all("win_sat", int'(WIN), 31, 0, 0);

        do_reset();
        btn_kick = 1'b1;
        tick();
        btn_kick = 1'b0;
        repeat (15) tick();
        expect_all("pre_rst", int'(KICK), 15, 1, 0);
        #2 reset = 1'b0;
        #1 expect_all("async_rst", int'(NOTHING), 0, 0, 0);
        tick();
        check("rst_no_done", int'(action_done), 0);
        reset = 1'b1;
        @(negedge clk);

        do_reset();
        btn_kick = 1'b1;
        tick();
        btn_kick = 1'b0;
        repeat (10) tick();
        expect_all("buf_k10", int'(KICK), 10, 1, 0);
        @(negedge clk) btn_grab = 1'b1;
        @(negedge clk) btn_grab = 1'b0;
        repeat (5) tick();
        expect_all("buf_k15", int'(KICK), 15, 1, 0);
        tick();
`ifdef INPUT_BUFFER_EN
        expect_all("buf_end", int'(GRAB), 0, 1, 1);
`else
        expect_all("buf_end", int'(NOTHING), 0, 0, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
